// File: rtl/trng_collector.sv
`default_nettype none
// ============================================================================
// trng_collector - ring-oscillator entropy harvester: sync, XOR-combine,
// optional von Neumann debias, repetition-count health test, word packing.
// Revision: 1.0
// ============================================================================
module trng_collector #(
  parameter int N_CH       = 2,
  parameter int WORD_W     = 32,
  parameter int SAMPLE_DIV = 8,
  parameter int WARMUP_CYC = 64,
  parameter int REP_LIMIT  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              debias_en_i,
  input  logic [N_CH-1:0]   entropy_i,
  input  logic              clear_fail_i,
  output logic              osc_rst_o,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              health_fail_o
);

  localparam int c_div_w = $clog2(SAMPLE_DIV);
  localparam int c_wu_w  = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam int c_cnt_w = $clog2(WORD_W + 1);
  localparam int c_rep_w = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_FAIL   = 2'd3
  } state_t;

  logic [N_CH-1:0]    sync1_q, sync2_q;
  state_t             state_q, state_d;
  logic               osc_rst_q, osc_rst_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               fail_q, fail_d;
  logic [c_div_w-1:0] div_q, div_d;
  logic [c_wu_w-1:0]  wu_q, wu_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               pair_vld_q, pair_vld_d;
  logic               pair_bit_q, pair_bit_d;
  logic               dbmode_q, dbmode_d;
  logic               prev_q, prev_d;
  logic [c_rep_w-1:0] rep_q, rep_d;

  logic               w_raw, w_strobe, w_emit, w_emit_bit, w_pair_v, w_full;
  logic [c_rep_w-1:0] w_rep_next;
  logic [WORD_W-1:0]  w_shift;

  // Two-flop synchroniser per free-running oscillator channel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= entropy_i;
      sync2_q <= sync1_q;
    end
  end

  assign w_raw    = ^sync2_q;
  assign w_strobe = (state_q == S_RUN) && (div_q == c_div_w'(SAMPLE_DIV - 1));
  assign w_full   = (cnt_q == c_cnt_w'(WORD_W));

  always_comb begin
    state_d    = state_q;
    osc_rst_d  = osc_rst_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fail_d     = fail_q;
    div_d      = div_q;
    wu_d       = wu_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    pair_vld_d = pair_vld_q;
    pair_bit_d = pair_bit_q;
    dbmode_d   = dbmode_q;
    prev_d     = prev_q;
    rep_d      = rep_q;
    w_emit     = 1'b0;
    w_emit_bit = 1'b0;
    w_pair_v   = 1'b0;
    w_rep_next = '0;
    w_shift    = '0;

    if (!en_i) begin
      state_d   = S_IDLE;
      osc_rst_d = 1'b1;
      valid_d   = 1'b0;
      cnt_d     = '0;
      acc_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_WARMUP;
          osc_rst_d = 1'b0;
          wu_d      = '0;
        end
        S_WARMUP: begin
          if (wu_q == c_wu_w'(WARMUP_CYC - 1)) begin
            state_d    = S_RUN;
            div_d      = '0;
            cnt_d      = '0;
            pair_vld_d = 1'b0;
            rep_d      = '0;
            prev_d     = 1'b0;
          end else begin
            wu_d = wu_q + c_wu_w'(1);
          end
        end
        S_RUN: begin
          div_d = w_strobe ? '0 : div_q + c_div_w'(1);
          if (w_strobe) begin
            w_rep_next = (w_raw == prev_q) ? rep_q + c_rep_w'(1) : c_rep_w'(1);
            rep_d      = w_rep_next;
            prev_d     = w_raw;
            if (w_rep_next == c_rep_w'(REP_LIMIT)) begin
              state_d   = S_FAIL;
              osc_rst_d = 1'b1;
              fail_d    = 1'b1;
              valid_d   = 1'b0;
              acc_d     = '0;
              cnt_d     = '0;
            end else begin
              dbmode_d = debias_en_i;
              // A mode change abandons any half-collected pair.
              w_pair_v = pair_vld_q && (debias_en_i == dbmode_q);
              if (!debias_en_i) begin
                w_emit     = 1'b1;
                w_emit_bit = w_raw;
                pair_vld_d = 1'b0;
              end else if (!w_pair_v) begin
                pair_vld_d = 1'b1;
                pair_bit_d = w_raw;
              end else begin
                pair_vld_d = 1'b0;
                w_emit     = (pair_bit_q != w_raw);
                w_emit_bit = pair_bit_q;
              end
            end
          end

          if (state_d == S_RUN) begin
            w_shift = {acc_q[WORD_W-2:0], w_emit_bit};
            if (w_full && (!valid_q || ready_i)) begin
              data_d  = acc_q;
              valid_d = 1'b1;
              if (w_emit) begin
                acc_d = w_shift;
                cnt_d = c_cnt_w'(1);
              end else begin
                cnt_d = '0;
              end
            end else begin
              if (valid_q && ready_i) valid_d = 1'b0;
              if (w_emit && !w_full) begin
                acc_d = w_shift;
                cnt_d = cnt_q + c_cnt_w'(1);
              end
            end
          end
        end
        S_FAIL: begin
          if (clear_fail_i) begin
            state_d   = S_WARMUP;
            osc_rst_d = 1'b0;
            fail_d    = 1'b0;
            wu_d      = '0;
          end
        end
        default: begin
          state_d   = S_IDLE;
          osc_rst_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      osc_rst_q  <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fail_q     <= 1'b0;
      div_q      <= '0;
      wu_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      pair_vld_q <= 1'b0;
      pair_bit_q <= 1'b0;
      dbmode_q   <= 1'b0;
      prev_q     <= 1'b0;
      rep_q      <= '0;
    end else begin
      state_q    <= state_d;
      osc_rst_q  <= osc_rst_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fail_q     <= fail_d;
      div_q      <= div_d;
      wu_q       <= wu_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      pair_vld_q <= pair_vld_d;
      pair_bit_q <= pair_bit_d;
      dbmode_q   <= dbmode_d;
      prev_q     <= prev_d;
      rep_q      <= rep_d;
    end
  end

  assign osc_rst_o     = osc_rst_q;
  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign health_fail_o = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_collector.sv
`default_nettype none
// ============================================================================
// tb_trng_collector - directed bench for trng_collector (WORD_W=8, SAMPLE_DIV=4).
// Revision: 1.0
// ============================================================================
module tb_trng_collector;

  localparam int WW = 8;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          debias = 1'b0;
  logic          clr = 1'b0;
  logic          rdy = 1'b0;
  logic [1:0]    ent = 2'b00;
  logic          osc_rst, valid, hfail;
  logic [WW-1:0] data;

  int   total = 0;
  int   bad = 0;
  int   to_strobe = 0;
  logic tog = 1'b0;

  always #5 clk = ~clk;

  trng_collector #(
    .N_CH(2), .WORD_W(WW), .SAMPLE_DIV(SD), .WARMUP_CYC(4), .REP_LIMIT(32)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .debias_en_i(debias),
    .entropy_i(ent), .clear_fail_i(clr), .osc_rst_o(osc_rst),
    .data_o(data), .valid_o(valid), .ready_i(rdy), .health_fail_o(hfail)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (to_strobe > 0) to_strobe--;
  endtask

  // Raw value b is the XOR of both channels; channel 0 toggles to exercise the combine.
  task automatic send_bit(input logic b);
    ent = {b ^ tog, tog};
    tog = ~tog;
    repeat (to_strobe) tick();
    to_strobe = SD;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  // Returns one tick after the WARMUP entry edge; first strobe is 8 edges later.
  task automatic start_run();
    logic ok;
    ok = 1'b0;
    to_strobe = 0;
    en = 1'b0;
    tick();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (osc_rst === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("warmup_enter", ok, 1);
    to_strobe = 2 * SD;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] dv;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_osc", osc_rst, 1);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_fail", hfail, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_hold", osc_rst, 1);

    // Raw packing: 1,0,1,1,0,0,1,0 -> B2
    rdy = 1'b1;
    debias = 1'b0;
    start_run();
    send_word(8'hB2);
    chk("raw_valid_early", valid, 0);
    tick();
    chk("raw_valid", valid, 1);
    chk("raw_data", data, 32'hB2);

    // Debias: pairs 01,10,11,00,10,10,01,01,10,01 -> 0,1,1,1,0,0,1,0 = 72
    debias = 1'b1;
    dv = 20'h6CA59;
    send_bit(dv[19]);
    chk("raw_xfer", valid, 0);
    for (int i = 18; i >= 0; i--) send_bit(dv[i]);
    chk("db_valid_early", valid, 0);
    tick();
    chk("db_valid", valid, 1);
    chk("db_data", data, 32'h72);

    // Backpressure: three words with ready low, third word dropped
    debias = 1'b0;
    send_bit(1'b1);
    chk("db_xfer", valid, 0);
    rdy = 1'b0;
    for (int i = 6; i >= 0; i--) send_bit(8'hA5 >> i);
    send_word(8'h3C);
    chk("bp_valid1", valid, 1);
    chk("bp_hold1", data, 32'hA5);
    send_word(8'h0F);
    chk("bp_valid2", valid, 1);
    chk("bp_hold2", data, 32'hA5);
    rdy = 1'b1;
    tick();
    chk("bp_second_valid", valid, 1);
    chk("bp_second_data", data, 32'h3C);
    tick();
    chk("bp_drain", valid, 0);

    // Disable with cnt=5 and a pending word
    rdy = 1'b0;
    start_run();
    send_word(8'hC3);
    repeat (5) send_bit(1'b1);
    chk("dis_valid_pre", valid, 1);
    chk("dis_data_pre", data, 32'hC3);
    en = 1'b0;
    tick();
    chk("dis_valid", valid, 0);
    chk("dis_osc", osc_rst, 1);
    tick();
    tick();
    chk("dis_idle", osc_rst, 1);
    rdy = 1'b1;
    start_run();
    send_word(8'h5A);
    chk("reen_valid_early", valid, 0);
    tick();
    chk("reen_valid", valid, 1);
    chk("reen_data", data, 32'h5A);

    // Health: constant raw 0 -> FAIL on 32nd strobe
    rdy = 1'b0;
    start_run();
    repeat (31) send_bit(1'b0);
    chk("hl_pass", hfail, 0);
    chk("hl_valid_pre", valid, 1);
    chk("hl_osc_pre", osc_rst, 0);
    send_bit(1'b0);
    chk("hl_fail", hfail, 1);
    chk("hl_osc", osc_rst, 1);
    chk("hl_valid", valid, 0);
    tick();
    tick();
    chk("hl_sticky", hfail, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("hl_clear", hfail, 0);
    chk("hl_warmup", osc_rst, 0);

    // Asynchronous reset mid-run with a word pending
    rdy = 1'b0;
    start_run();
    send_word(8'h96);
    tick();
    chk("rs_valid_pre", valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_osc", osc_rst, 1);
    chk("rs_valid", valid, 0);
    chk("rs_data", data, 0);
    chk("rs_fail", hfail, 0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rs_idle", osc_rst, 1);
    en = 1'b1;
    tick();
    chk("rs_leave", osc_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trng_collector.md
# trng_collector

Parametrised entropy harvester for the TRNG path. It sits between the ring-oscillator macros and the memory-side consumer. It controls oscillator reset, synchronises N free-running ring outputs into the system clock and combines them. It optionally debiases the stream (von Neumann), runs a repetition-count health test, and packs accepted bits into words delivered over a valid/ready handshake.

## Interface
- N_CH, default 2: number of ring-oscillator entropy channels, ≥1.
- WORD_W, default 32: output word width, ≥2.
- SAMPLE_DIV, default 8: clocks per sample strobe, ≥2.
- WARMUP_CYC, default 64: clocks discarded after oscillator release, ≥1.
- REP_LIMIT, default 32: raw-bit run length declared a health failure, ≥2.
- clk_i  in  1  system clock; the block's only clock.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  collector enable.
- debias_en_i  in  1  1 = von Neumann debias; 0 = raw bits.
- entropy_i  in  N_CH  asynchronous ring-oscillator outputs.
- clear_fail_i  in  1  leaves FAIL.
- osc_rst_o  out  1  drives ring-oscillator reset.
- data_o  out  WORD_W  entropy word.
- valid_o  out  1  data_o valid.
- ready_i  in  1  consumer accepts data_o.
- health_fail_o  out  1  sticky health-test failure flag.

## Operation
- Reset values: state IDLE, osc_rst_o=1, data_o=0, valid_o=0, health_fail_o=0. Synchronisers, divider, accumulator, bit count, pair and repetition registers are all 0.
- Each entropy_i bit passes through a 2-flop synchroniser. raw = XOR of all synchronised channels.

**States**
- IDLE: osc_rst_o=1. en_i=1 → WARMUP.
- WARMUP: osc_rst_o=0. Counts WARMUP_CYC clocks, then → RUN. Divider, bit count, pair state and repetition counter are cleared on entry to RUN.
- RUN: divider counts 0..SAMPLE_DIV-1. Strobe fires when it equals SAMPLE_DIV-1. The first strobe falls SAMPLE_DIV clocks after entering RUN.
- FAIL: osc_rst_o=1, no sampling, valid_o=0, accumulator cleared, health_fail_o=1. clear_fail_i=1 → WARMUP and clears health_fail_o on the same edge.
- en_i=0 → IDLE from any state, with priority over clear_fail_i and health. Bit count and valid_o are cleared; any pending word is discarded.

**Health test (every strobe)**
- If raw equals the previous raw, rep_cnt increments; otherwise rep_cnt=1.
- The strobe that brings rep_cnt to REP_LIMIT moves to FAIL on that edge. That bit is not emitted.

**Debias**
- debias_en_i=0: every raw bit is emitted.
- debias_en_i=1: the first bit of a pair is stored. On the second bit: 01 emits 0, 10 emits 1, 00/11 emit nothing. Pair state is then cleared.
- debias_en_i is sampled per strobe. Changing it mid-pair clears the pair state.

**Packing**
- On each emitted bit: acc <= {acc[WORD_W-2:0], bit}, cnt++. The first emitted bit ends at the MSB.
- When cnt==WORD_W and (valid_o==0 or ready_i==1): acc → data_o, valid_o=1, cnt=0.
- While cnt==WORD_W and the transfer is blocked, further emitted bits are discarded and the accumulator holds.
- Handshake: a transfer occurs on an edge with valid_o && ready_i. data_o is stable while valid_o=1 and ready_i=0. valid_o never drops without a transfer, except on en_i=0, FAIL or reset.
- Accept and refill on the same edge: the new word loads and valid_o stays 1.

## Timing
- Input to raw: 2 clocks of synchroniser latency.
- Emitted bit to cnt update: same strobe edge.
- cnt reaching WORD_W to valid_o=1: 1 clock, if unblocked.
- Maximum raw-mode throughput: one word per WORD_W×SAMPLE_DIV clocks.
- State transitions take effect on the edge after the condition. osc_rst_o is registered and follows the state with no extra delay.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Leaving IDLE requires en_i=1 after deassertion.

## Test plan
- Reset: set rst_i during RUN with valid_o=1 → osc_rst_o=1, valid_o=0, data_o=0, health_fail_o=0 immediately; IDLE until en_i.
- Raw packing: N_CH=2, WORD_W=8, SAMPLE_DIV=4, WARMUP_CYC=4, debias off, ready_i=1. Drive raw sequence 1,0,1,1,0,0,1,0 → data_o=8'hB2, valid_o one clock after the 8th strobe.
- Debias: raw pairs 01,10,11,00,10,10,01,01,10,01 → 8 emitted bits 0,1,1,1,0,0,1,0 → data_o=8'h72. Pairs 11 and 00 produce no bits.
- Backpressure: ready_i=0 across three words' worth of strobes. The first word holds on data_o and the second fills the accumulator; the third word's bits are dropped. Raise ready_i → first then second word transfer in order, then valid_o=0.
- Health: REP_LIMIT=32, entropy held constant → FAIL on the 32nd strobe of the run: health_fail_o=1, valid_o=0, osc_rst_o=1. Pulse clear_fail_i → WARMUP, health_fail_o=0.
- Disable: drop en_i with cnt=5 and valid_o=1 → next edge IDLE, valid_o=0, osc_rst_o=1. Re-enable → full warmup, and the next word uses only new bits.
